// File: rtl/io_input_conditioner.sv
// Synchronizes and debounces four independent 8-bit external input ports for the CPU.
// Latency: an accepted byte appears on in_pN (with chg_pN) DEBOUNCE_CYCLES+3 edges after the raw change.
// No backpressure: free-running inputs in, registered outputs out, every cycle.

// One conditioning channel: 2-flop synchronizer followed by a byte-wise debounce filter.
module io_input_conditioner_chan #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable,
  output logic             chg
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Two-stage synchronizer; only sync2 is ever used by the filter.
  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;

  // Candidate byte under observation and how long it has held.
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Accepted byte and its one-cycle change strobe.
  logic [WIDTH-1:0] stable_q, stable_d;
  logic             chg_q, chg_d;

  // Debounce next-state: any bit change restarts the whole byte's count;
  // the count saturates and acceptance fires once per differing candidate.
  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    chg_d    = 1'b0;

    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (stable_q != cand_q) begin
      stable_d = cand_q;
      chg_d    = 1'b1;
    end
  end

  // State registers; reset discards any pending candidate and leaves the count settled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      cnt_q    <= CNT_MAX;
      stable_q <= '0;
      chg_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      chg_q    <= chg_d;
    end
  end

  assign stable = stable_q;
  assign chg    = chg_q;

endmodule

// Four identical, fully independent conditioning channels.
module io_input_conditioner #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_p0,
  input  logic [WIDTH-1:0] raw_p1,
  input  logic [WIDTH-1:0] raw_p2,
  input  logic [WIDTH-1:0] raw_p3,
  output logic [WIDTH-1:0] in_p0,
  output logic [WIDTH-1:0] in_p1,
  output logic [WIDTH-1:0] in_p2,
  output logic [WIDTH-1:0] in_p3,
  output logic             chg_p0,
  output logic             chg_p1,
  output logic             chg_p2,
  output logic             chg_p3
);

  logic [3:0][WIDTH-1:0] raw_vec;
  logic [3:0][WIDTH-1:0] in_vec;
  logic [3:0]            chg_vec;

  assign raw_vec = {raw_p3, raw_p2, raw_p1, raw_p0};

  for (genvar i = 0; i < 4; i++) begin : g_chan
    io_input_conditioner_chan #(
      .WIDTH           (WIDTH),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .raw    (raw_vec[i]),
      .stable (in_vec[i]),
      .chg    (chg_vec[i])
    );
  end

  assign in_p0  = in_vec[0];
  assign in_p1  = in_vec[1];
  assign in_p2  = in_vec[2];
  assign in_p3  = in_vec[3];
  assign chg_p0 = chg_vec[0];
  assign chg_p1 = chg_vec[1];
  assign chg_p2 = chg_vec[2];
  assign chg_p3 = chg_vec[3];

endmodule
